// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite bus encodings and the data-phase state encoding of the SRAM slave.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] D_IDLE   = 3'd0;
    localparam logic [2:0] D_WAIT   = 3'd1;
    localparam logic [2:0] D_ACCESS = 3'd2;
    localparam logic [2:0] D_ERR1   = 3'd3;
    localparam logic [2:0] D_ERR2   = 3'd4;

endpackage

// File: rtl/ahb_sram_slave_burst_addr.sv
// Next expected burst address from the current beat: INCR steps by the transfer size,
// WRAPn increments only inside an n*size aligned window.
module ahb_burst_addr
    import ahb_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step = ADDR_W'(1) << hsize;
        incr = addr + step;
        case (hburst)
            HBURST_WRAP4:  wrap_mask = (step << 2) - ADDR_W'(1);
            HBURST_WRAP8:  wrap_mask = (step << 3) - ADDR_W'(1);
            HBURST_WRAP16: wrap_mask = (step << 4) - ADDR_W'(1);
            default:       wrap_mask = '0;
        endcase
        if (wrap_mask == '0) begin
            next_addr = incr;
        end else begin
            next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// Parametrised AHB-Lite SRAM slave: pipelined address/data phases, byte-lane writes,
// programmable wait states, two-cycle ERROR response and optional SEQ address checking.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int BURST_CHECK = 1
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [4:0]        beat_cnt
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [4:0]        beat_cnt_q, beat_cnt_d;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] size_mask;
    logic              accept;
    logic              addr_err;
    logic [NBYTES-1:0] lane_en;
    logic [31:0]       lane_off;
    logic [31:0]       lane_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic              unused_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    assign unused_ok = ^{hprot, hmastlock};

    ahb_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
        .addr      (haddr),
        .hsize     (hsize),
        .hburst    (hburst),
        .next_addr (next_addr)
    );

    // A new address phase can only complete while our own data phase is completing.
    assign hreadyout = (state_q != D_WAIT) && (state_q != D_ERR1);
    assign hresp     = ((state_q == D_ERR1) || (state_q == D_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign accept    = hsel && hready && hreadyout && htrans[1];
    assign beat_cnt  = beat_cnt_q;

    always_comb begin
        size_mask = ADDR_W'((32'd1 << hsize) - 32'd1);
        addr_err  = (32'(haddr >> LANE_W) >= 32'(DEPTH))
                 || (32'(hsize) > 32'(LANE_W))
                 || ((haddr & size_mask) != '0)
                 || ((BURST_CHECK != 0) && (htrans == HTRANS_SEQ) && (haddr != exp_addr_q));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        exp_addr_d = exp_addr_q;
        write_d    = write_q;
        size_d     = size_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            D_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) state_d = D_ACCESS;
            end
            D_ERR1:  state_d = D_ERR2;
            default: state_d = D_IDLE;
        endcase

        if (accept) begin
            addr_d     = haddr;
            write_d    = hwrite;
            size_d     = hsize;
            exp_addr_d = next_addr;
            if (addr_err) begin
                state_d = D_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d    = D_WAIT;
                wait_cnt_d = 4'(WAIT_STATES);
            end else begin
                state_d = D_ACCESS;
            end
        end

        if (hsel && hready && hreadyout) begin
            case (htrans)
                HTRANS_SEQ:  if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
                HTRANS_BUSY: beat_cnt_d = beat_cnt_q;
                default:     beat_cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= D_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            exp_addr_q <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            exp_addr_q <= exp_addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Little-endian lanes: the transfer occupies 2**size lanes starting at the low address bits.
    always_comb begin
        lane_off = 32'(addr_q) & 32'(NBYTES - 1);
        lane_cnt = 32'd1 << size_q;
        for (int l = 0; l < NBYTES; l++) begin
            lane_en[l] = (32'(l) >= lane_off) && (32'(l) < lane_off + lane_cnt);
        end
    end

    assign word_idx = IDX_W'(addr_q >> LANE_W);
    assign hrdata   = ((state_q == D_ACCESS) && !write_q) ? mem[word_idx] : '0;

    always_ff @(posedge hclk) begin
        if ((state_q == D_ACCESS) && write_q) begin
            for (int l = 0; l < NBYTES; l++) begin
                if (lane_en[l]) mem[word_idx][8*l +: 8] <= hwdata[8*l +: 8];
            end
        end
    end

endmodule
